// File: rtl/multicycle_ctrl.sv
// Multicycle CPU main control unit.
// Moore FSM that sequences fetch/decode/execute/memory/writeback for a small
// MIPS-like subset (R-type, lw, sw, beq, j, addi). Besides the datapath
// controls it exposes the current state code, a one-cycle illegal-opcode flag
// and a wrapping count of retired instructions.
//
// Handshake: mem_req is held high for as long as the FSM waits on memory;
// mem_ready is a completion strobe that only has meaning while mem_req=1.
// The cycle in which mem_ready=1 is seen ends the wait, and the write strobes
// tied to that access (ir_we/pc_we in FETCH, mem_we in MEM_WRITE) pulse in
// that same cycle.
module multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             iord,
    output logic             ir_we,
    output logic             pc_we,
    output logic             mem_we,
    output logic             reg_we,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic [2:0]       AluOp,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC      = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t           r_state;
    state_t           w_next;
    logic             r_illegal_op;
    logic [CNT_W-1:0] r_retired;
    logic             w_op_known;
    logic             w_retire;

    assign state      = r_state;
    assign illegal_op = r_illegal_op;
    assign retired    = r_retired;

    // Opcodes the decoder dispatches on; anything else is dropped back to FETCH.
    always_comb begin
        w_op_known = 1'b0;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: w_op_known = 1'b1;
            default:                                       w_op_known = 1'b0;
        endcase
    end

    // An instruction retires on the edge that takes its final state back to FETCH.
    always_comb begin
        w_retire = 1'b0;
        if (w_next == S_FETCH) begin
            case (r_state)
                S_MEM_WB, S_MEM_WRITE, S_ALU_WB, S_ADDI_WB, S_BRANCH, S_JUMP:
                    w_retire = 1'b1;
                default:
                    w_retire = 1'b0;
            endcase
        end
    end

    // State, illegal-opcode flag and retire counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FETCH;
            r_illegal_op <= 1'b0;
            r_retired    <= '0;
        end else begin
            r_state      <= w_next;
            r_illegal_op <= (r_state == S_DECODE) && !w_op_known;
            if (w_retire) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    // Next-state and Moore outputs; every control defaults to 0.
    // The FETCH strobes are qualified with rst_n so that a memory completion
    // arriving while reset is held cannot write IR or PC.
    always_comb begin
        w_next     = r_state;
        mem_req    = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        mem_we     = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        AluOp      = 3'b000;
        case (r_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_we  = rst_n;
                    pc_we  = rst_n;
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDI_EXEC;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = (op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    mem_we = 1'b1;
                    w_next = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                AluOp     = 3'b111;
                w_next    = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_we  = 1'b1;
                reg_dst = 1'b1;
                w_next  = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                AluOp     = 3'b001;
                pc_src    = 2'b01;
                pc_we     = zero;
                w_next    = S_FETCH;
            end
            S_JUMP: begin
                pc_src = 2'b10;
                pc_we  = 1'b1;
                w_next = S_FETCH;
            end
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_we = 1'b1;
                w_next = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (CNT_W=4 so the retire counter wraps).
// Each instruction pushes its expected state trace into exp_q; every cycle
// pops one entry and compares it with the state output, and per-state
// control outputs are checked against constants at the relevant cycles.
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;

    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2,
        MEM_READ = 4'd3, MEM_WB = 4'd4, MEM_WRITE = 4'd5, EXEC = 4'd6,
        ALU_WB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9, ADDI_EXEC = 4'd10,
        ADDI_WB = 4'd11;

    logic             clk;
    logic             rst_n;
    logic [5:0]       op;
    logic             zero;
    logic             mem_ready;
    logic             mem_req, iord, ir_we, pc_we, mem_we, reg_we;
    logic             reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]       alu_src_b, pc_src;
    logic [2:0]       AluOp;
    logic [3:0]       state;
    logic             illegal_op;
    logic [CNT_W-1:0] retired;

    logic [3:0]       exp_q[$];
    int               n_checks = 0;
    int               n_err    = 0;
    int               exp_ret  = 0;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .iord       (iord),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .mem_we     (mem_we),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .AluOp      (AluOp),
        .state      (state),
        .illegal_op (illegal_op),
        .retired    (retired)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    // ---------------- checker / driver tasks ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive mem_ready for the current cycle, let outputs settle, and compare
    // the state against the next scoreboard entry.
    task automatic drive(input logic mr);
        logic [3:0] e;
        mem_ready = mr;
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $error("FAIL sb_empty: observed=%0d expected=entry", state);
        end else begin
            e = exp_q.pop_front();
            chk("state", {28'd0, state}, {28'd0, e});
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_trace(input logic [3:0] s0, input logic [3:0] s1,
                              input logic [3:0] s2, input logic [3:0] s3,
                              input int n);
        logic [3:0] t[4];
        t[0] = s0; t[1] = s1; t[2] = s2; t[3] = s3;
        for (int i = 0; i < n; i++) exp_q.push_back(t[i]);
    endtask

    task automatic chk_no_we(input string tag);
        chk({tag, "_we"}, {28'd0, ir_we, pc_we, mem_we, reg_we}, 32'd0);
    endtask

    task automatic chk_retired(input string tag);
        chk(tag, {28'd0, retired}, exp_ret % (1 << CNT_W));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; op = 6'd0; zero = 1'b0; mem_ready = 1'b0;
        tick();
        #1;
        chk("rst_state", {28'd0, state}, 32'd0);
        chk_retired("rst_retired");
        chk("rst_illegal", {31'd0, illegal_op}, 32'd0);
        chk("rst_fetch_ctl", {23'd0, mem_req, iord, alu_src_a, alu_src_b, AluOp, pc_src}, 32'b1_0_0_01_000_00);
        chk_no_we("rst");
        mem_ready = 1'b1; #1;
        chk("rst_mr_hi_we", {30'd0, ir_we, pc_we}, 32'd0);
        tick();
        rst_n = 1'b1;

        // R-type
        op = 6'b000000;
        push_trace(FETCH, DECODE, EXEC, ALU_WB, 4); push_trace(FETCH, 0, 0, 0, 1);
        drive(1); chk("rt_fetch_we", {30'd0, ir_we, pc_we}, 32'b11); tick();
        drive(0); chk("rt_dec_ctl", {26'd0, alu_src_a, alu_src_b, AluOp}, 32'b0_11_000); tick();
        drive(0); chk("rt_exec_ctl", {26'd0, alu_src_a, alu_src_b, AluOp}, 32'b1_00_111); tick();
        drive(0); chk("rt_wb_ctl", {29'd0, reg_we, reg_dst, mem_to_reg}, 32'b110); tick();
        exp_ret++;
        drive(0); chk_retired("rt_retired"); chk_no_we("rt_fetch_idle"); tick();

        // lw with a 3-cycle stall; mem_ready=1 in MEM_ADDR must be ignored
        op = 6'b100011;
        push_trace(FETCH, DECODE, MEM_ADDR, MEM_READ, 4);
        push_trace(MEM_READ, MEM_READ, MEM_READ, MEM_WB, 4); push_trace(FETCH, 0, 0, 0, 1);
        drive(1); tick();
        drive(0); tick();
        drive(1); chk("lw_addr_ctl", {26'd0, alu_src_a, alu_src_b, AluOp}, 32'b1_10_000);
        chk("lw_addr_req", {31'd0, mem_req}, 32'd0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(0); chk("lw_stall_req", {30'd0, mem_req, iord}, 32'b11); chk_no_we("lw_stall"); tick();
        end
        drive(1); tick();
        drive(0); chk("lw_wb_ctl", {29'd0, reg_we, reg_dst, mem_to_reg}, 32'b101); tick();
        exp_ret++;
        drive(0); chk_retired("lw_retired"); tick();

        // sw with one stall cycle
        op = 6'b101011;
        push_trace(FETCH, DECODE, MEM_ADDR, MEM_WRITE, 4); push_trace(MEM_WRITE, FETCH, 0, 0, 2);
        drive(1); tick(); drive(0); tick(); drive(0); tick();
        drive(0); chk("sw_wait_mem_we", {31'd0, mem_we}, 32'd0); tick();
        drive(1); chk("sw_mem_we", {29'd0, mem_req, iord, mem_we}, 32'b111); tick();
        exp_ret++;
        drive(0); chk_retired("sw_retired"); tick();

        // beq taken then not taken
        for (int z = 1; z >= 0; z--) begin
            op = 6'b000100; zero = z[0];
            push_trace(FETCH, DECODE, BRANCH, FETCH, 4);
            drive(1); tick(); drive(0); tick();
            drive(0);
            chk("beq_ctl", {26'd0, alu_src_a, alu_src_b, AluOp}, 32'b1_00_001);
            chk("beq_pc", {29'd0, pc_src, pc_we}, {29'd0, 2'b01, z[0]});
            tick();
            exp_ret++;
            drive(0); chk_retired("beq_retired"); tick();
        end
        zero = 1'b0;

        // illegal opcode
        op = 6'b111111;
        push_trace(FETCH, DECODE, FETCH, FETCH, 4);
        drive(1); tick();
        drive(0); chk("ill_pre", {31'd0, illegal_op}, 32'd0); tick();
        drive(0); chk("ill_flag", {31'd0, illegal_op}, 32'd1); chk_retired("ill_retired");
        chk_no_we("ill"); tick();
        drive(0); chk("ill_clear", {31'd0, illegal_op}, 32'd0); tick();

        // addi
        op = 6'b001000;
        push_trace(FETCH, DECODE, ADDI_EXEC, ADDI_WB, 4); push_trace(FETCH, 0, 0, 0, 1);
        drive(1); tick(); drive(0); tick();
        drive(0); chk("addi_ex_ctl", {26'd0, alu_src_a, alu_src_b, AluOp}, 32'b1_10_000); tick();
        drive(0); chk("addi_wb_ctl", {29'd0, reg_we, reg_dst, mem_to_reg}, 32'b100); tick();
        exp_ret++;
        drive(0); chk_retired("addi_retired"); tick();

        // 16 jumps wrap the 4-bit counter back to its starting value
        op = 6'b000010;
        for (int j = 0; j < 16; j++) begin
            push_trace(FETCH, DECODE, JUMP, FETCH, 4);
            drive(1); tick(); drive(0); tick();
            drive(0); chk("j_pc", {29'd0, pc_src, pc_we}, 32'b10_1); tick();
            exp_ret++;
            drive(0); chk_retired("j_retired"); tick();
        end

        // async reset while stalled in MEM_WRITE
        op = 6'b101011;
        push_trace(FETCH, DECODE, MEM_ADDR, MEM_WRITE, 4); push_trace(MEM_WRITE, 0, 0, 0, 1);
        drive(1); tick(); drive(0); tick(); drive(0); tick(); drive(0); tick();
        drive(0);
        #2 rst_n = 1'b0;
        #1;
        exp_ret = 0;
        chk("arst_state", {28'd0, state}, 32'd0);
        chk_retired("arst_retired");
        chk_no_we("arst");
        mem_ready = 1'b1; #1;
        chk_no_we("arst_mr_hi");
        tick();
        mem_ready = 1'b0;
        rst_n = 1'b1;

        // recovery: one more R-type after reset
        op = 6'b000000;
        push_trace(FETCH, DECODE, EXEC, ALU_WB, 4); push_trace(FETCH, 0, 0, 0, 1);
        drive(1); tick(); drive(0); tick(); drive(0); tick(); drive(0); tick();
        exp_ret++;
        drive(0); chk_retired("post_rst_retired"); tick();

        chk("sb_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port op, input, 6, instruction opcode field from the IR.
REQ-005 SHALL have port zero, input, 1, ALU zero flag.
REQ-006 SHALL have port mem_ready, input, 1, memory completion strobe.
REQ-007 SHALL have port mem_req, output, 1, memory access request.
REQ-008 SHALL have ports iord, ir_we, pc_we, mem_we, reg_we, reg_dst, mem_to_reg, alu_src_a, each output, 1, datapath enables and selects.
REQ-009 SHALL have ports alu_src_b and pc_src, output, 2 each, datapath mux selects.
REQ-010 SHALL have port AluOp, output, 3, ALU-control code: 000 add, 001 sub, 111 R-type (func decoded downstream).
REQ-011 SHALL have ports state, output, 4, current state code; illegal_op, output, 1; retired, output, CNT_W.

Function
REQ-012 SHALL implement a Moore FSM with these codes: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC=6, ALU_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11.
REQ-013 Transitions:
- FETCH to DECODE only on mem_ready=1; otherwise hold.
- DECODE by op: 000000 to EXEC; 100011/101011 to MEM_ADDR; 000100 to BRANCH; 000010 to JUMP; 001000 to ADDI_EXEC; any other opcode to FETCH.
REQ-014 Further transitions:
- MEM_ADDR to MEM_READ (lw) or MEM_WRITE (sw), using op sampled in that cycle.
- MEM_READ to MEM_WB on mem_ready=1, else hold.
- MEM_WRITE to FETCH on mem_ready=1, else hold.
- EXEC to ALU_WB; ADDI_EXEC to ADDI_WB.
- MEM_WB, ALU_WB, ADDI_WB, BRANCH, JUMP to FETCH.
REQ-015 FETCH outputs: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, AluOp=000, pc_src=00; ir_we=pc_we=1 only in the cycle mem_ready=1.
REQ-016 DECODE outputs: alu_src_a=0, alu_src_b=11, AluOp=000 (branch target precompute).
REQ-017 MEM_ADDR and ADDI_EXEC outputs: alu_src_a=1, alu_src_b=10, AluOp=000.
REQ-018 MEM_READ outputs: mem_req=1, iord=1. MEM_WRITE outputs: mem_req=1, iord=1, mem_we=1 only in the cycle mem_ready=1.
REQ-019 MEM_WB outputs: reg_we=1, reg_dst=0, mem_to_reg=1. ALU_WB outputs: reg_we=1, reg_dst=1, mem_to_reg=0. ADDI_WB outputs: reg_we=1, reg_dst=0, mem_to_reg=0.
REQ-020 EXEC outputs: alu_src_a=1, alu_src_b=00, AluOp=111.
REQ-021 BRANCH outputs: alu_src_a=1, alu_src_b=00, AluOp=001, pc_src=01; pc_we=zero.
REQ-022 JUMP outputs: pc_src=10, pc_we=1.
REQ-023 Every output not listed for a state SHALL be 0.
REQ-024 illegal_op SHALL be registered: set to 1 for exactly the one cycle following a DECODE with an unrecognised op, otherwise 0.
REQ-025 retired SHALL increment by 1 on each transition into FETCH from MEM_WB, MEM_WRITE, ALU_WB, ADDI_WB, BRANCH or JUMP; it wraps from all-ones to 0; illegal opcodes are not counted.
REQ-026 mem_ready SHALL be ignored in states that do not assert mem_req.

Reset
REQ-027 When rst_n=0, asynchronously and regardless of clk: state=FETCH, retired=0, illegal_op=0; outputs then follow FETCH with pc_we=ir_we=0 until mem_ready=1.
REQ-028 Reset asserted mid-instruction (any state, including a stalled memory wait) SHALL abort it with no further reg_we, mem_we or pc_we pulses.

Verification
REQ-029 R-type: op=000000, mem_ready=1 in FETCH -> states 0,1,6,7,0; AluOp=111 in EXEC; reg_we=1 with reg_dst=1 in ALU_WB; retired 0 to 1.
REQ-030 lw with 3-cycle stall in MEM_READ: op=100011, mem_ready low 3 cycles -> MEM_READ held 4 cycles (3 waiting plus 1 with mem_ready=1), then MEM_WB with mem_to_reg=1, reg_we=1; total 8 cycles FETCH to FETCH.
REQ-031 beq: op=000100 with zero=1 -> pc_we=1, pc_src=01 in BRANCH; repeat with zero=0 -> pc_we=0; both return to FETCH and increment retired.
REQ-032 Illegal opcode op=111111 -> DECODE to FETCH, illegal_op=1 for one cycle, retired unchanged, no write enables asserted.
REQ-033 Counter wrap with CNT_W=4: retire 16 jumps (op=000010) -> retired returns to 0, and pc_src=10, pc_we=1 in each JUMP.
REQ-034 Asynchronous reset: assert rst_n=0 between clock edges while stalled in MEM_WRITE -> state=0 and retired=0 immediately, with no mem_we pulse.
